// File: rtl/button_select_pkg.sv
// button_select_pkg: shared group encoding, default selections and bit-vector helpers
// Revision 1.0 - initial release
`default_nettype none

package button_select_pkg;

   typedef enum logic [1:0] {
      GRP_FREQ = 2'd0,
      GRP_LP   = 2'd1,
      GRP_HP   = 2'd2,
      GRP_NONE = 2'd3
   } group_t;

   localparam int C_FREQ_DEFAULT = 5;
   localparam int C_LP_DEFAULT   = 0;
   localparam int C_HP_DEFAULT   = 0;

   // Helpers operate on a fixed-width vector; callers zero-extend their bank into it.
   localparam int C_MAX_BTN = 32;
   localparam int C_IDX_W   = 5;
   localparam int C_CNT_W   = 6;

   function automatic logic [C_CNT_W-1:0] popcount(input logic [C_MAX_BTN-1:0] v);
      logic [C_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < C_MAX_BTN; i++) begin
         n = n + C_CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Lowest set bit wins; only meaningful when exactly one bit is set.
   function automatic logic [C_IDX_W-1:0] onehot_index(input logic [C_MAX_BTN-1:0] v);
      logic [C_IDX_W-1:0] idx;
      idx = '0;
      for (int i = C_MAX_BTN - 1; i >= 0; i--) begin
         if (v[i]) idx = C_IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic group_t group_of(input logic [C_IDX_W-1:0] idx,
                                       input int nf, input int nl, input int nh);
      group_t g;
      if (int'(idx) < nf)                g = GRP_FREQ;
      else if (int'(idx) < nf + nl)      g = GRP_LP;
      else if (int'(idx) < nf + nl + nh) g = GRP_HP;
      else                               g = GRP_NONE;
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus whole-vector debounce with a commit pulse
// Revision 1.0 - initial release
`default_nettype none

module button_debounce #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_n,
   output logic [WIDTH-1:0] cand,
   output logic [WIDTH-1:0] stable,
   output logic             commit
);

   localparam int            CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_stable;
   logic [CW-1:0]    r_cnt;
   logic             w_commit;

   // Commit is combinational so the selection registers load on the same edge as stable.
   assign w_commit = (r_cnt == C_CNT_MAX) && (r_cand != r_stable);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= '1;
         r_sync2  <= '1;
         r_cand   <= '1;
         r_stable <= '1;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= raw_n;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_commit) r_stable <= r_cand;
      end
   end

   assign cand   = r_cand;
   assign stable = r_stable;
   assign commit = w_commit;

endmodule

`default_nettype wire

// File: rtl/button_select_encoder.sv
// button_select_encoder: debounced button bank -> freq/lowpass/highpass selection registers
// Revision 1.0 - optional MULTI_PRESS_DEFAULT_EN: multi-press restores defaults
`default_nettype none

module button_select_encoder
   import button_select_pkg::*;
#(
   parameter int N_FREQ          = 8,
   parameter int N_LP            = 4,
   parameter int N_HP            = 4,
   parameter int FREQ_DEFAULT    = C_FREQ_DEFAULT,
   parameter int LP_DEFAULT      = C_LP_DEFAULT,
   parameter int HP_DEFAULT      = C_HP_DEFAULT,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N_FREQ+N_LP+N_HP-1:0] btn_n,
   output logic [$clog2(N_FREQ)-1:0]   freq_sel,
   output logic [$clog2(N_LP)-1:0]     lp_sel,
   output logic [$clog2(N_HP)-1:0]     hp_sel,
   output logic                        sel_upd,
   output logic                        multi_err
);

   localparam int NB = N_FREQ + N_LP + N_HP;
   localparam int FW = $clog2(N_FREQ);
   localparam int LW = $clog2(N_LP);
   localparam int HW = $clog2(N_HP);

   localparam logic [C_IDX_W-1:0] C_LP_BASE = C_IDX_W'(N_FREQ);
   localparam logic [C_IDX_W-1:0] C_HP_BASE = C_IDX_W'(N_FREQ + N_LP);

   logic [NB-1:0]      w_cand;
   logic [NB-1:0]      w_stable;
   logic               w_commit;
   logic [NB-1:0]      w_pressed;
   logic [NB-1:0]      w_new;
   logic [C_CNT_W-1:0] w_count;
   logic [C_IDX_W-1:0] w_idx;
   logic [C_IDX_W-1:0] w_local;
   group_t             w_grp;

   button_debounce #(
      .WIDTH           (NB),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_n   (btn_n),
      .cand    (w_cand),
      .stable  (w_stable),
      .commit  (w_commit)
   );

   assign w_pressed = ~w_cand;
   assign w_new     = ~w_cand & w_stable;
   assign w_count   = popcount(C_MAX_BTN'(w_pressed));
   assign w_idx     = onehot_index(C_MAX_BTN'(w_pressed));
   assign w_grp     = group_of(w_idx, N_FREQ, N_LP, N_HP);

   always_comb begin
      w_local = w_idx;
      case (w_grp)
         GRP_LP:  w_local = w_idx - C_LP_BASE;
         GRP_HP:  w_local = w_idx - C_HP_BASE;
         default: w_local = w_idx;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freq_sel  <= FW'(FREQ_DEFAULT);
         lp_sel    <= LW'(LP_DEFAULT);
         hp_sel    <= HW'(HP_DEFAULT);
         sel_upd   <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         sel_upd   <= 1'b0;
         multi_err <= 1'b0;
         if (w_commit) begin
            // A lone button that was already held (partner released) is not a new press.
            if (w_count == C_CNT_W'(1) && (|w_new)) begin
               sel_upd <= 1'b1;
               case (w_grp)
                  GRP_FREQ: freq_sel <= FW'(w_local);
                  GRP_LP:   lp_sel   <= LW'(w_local);
                  GRP_HP:   hp_sel   <= HW'(w_local);
                  default:  ;
               endcase
            end else if (w_count >= C_CNT_W'(2)) begin
               multi_err <= 1'b1;
`ifdef MULTI_PRESS_DEFAULT_EN
               sel_upd  <= 1'b1;
               freq_sel <= FW'(FREQ_DEFAULT);
               lp_sel   <= LW'(LP_DEFAULT);
               hp_sel   <= HW'(HP_DEFAULT);
`endif
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_button_select_encoder.sv
// tb_button_select_encoder: table-driven press sequences plus exact-latency and reset corner cases
// Revision 1.0 - initial release
`default_nettype none

module tb_button_select_encoder;

   localparam int D = 4;

`ifdef MULTI_PRESS_DEFAULT_EN
   localparam bit C_MP = 1'b1;
`else
   localparam bit C_MP = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [15:0] btn_n;
   logic [2:0]  freq_sel;
   logic [1:0]  lp_sel;
   logic [1:0]  hp_sel;
   logic        sel_upd;
   logic        multi_err;

   int n_tests;
   int n_fail;
   int upd_total;
   int err_total;
   int b2b_total;
   logic prev_upd;
   logic prev_err;

   typedef struct {
      logic [15:0] mask;
      int          cycles;
      int          f;
      int          l;
      int          h;
      int          upd;
      int          err;
   } vec_t;

   vec_t vecs[$];

   button_select_encoder #(
      .N_FREQ          (8),
      .N_LP            (4),
      .N_HP            (4),
      .FREQ_DEFAULT    (5),
      .LP_DEFAULT      (0),
      .HP_DEFAULT      (0),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_n     (btn_n),
      .freq_sel  (freq_sel),
      .lp_sel    (lp_sel),
      .hp_sel    (hp_sel),
      .sel_upd   (sel_upd),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (sel_upd) upd_total++;
      if (multi_err) err_total++;
      if ((sel_upd && prev_upd) || (multi_err && prev_err)) b2b_total++;
      prev_upd = sel_upd;
      prev_err = multi_err;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int k = 0; k < n; k++) after_edge();
   endtask

   task automatic add(input logic [15:0] m, input int c, input int f, input int l,
                      input int h, input int u, input int e);
      vec_t v;
      v.mask = m; v.cycles = c; v.f = f; v.l = l; v.h = h; v.upd = u; v.err = e;
      vecs.push_back(v);
   endtask

   // Press a mask at a known point and check the strobe lands exactly on edge D+3.
   task automatic latency_seq(input string tag, input int exp_f, input int exp_l, input int exp_h);
      for (int e = 1; e <= D + 4; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == D + 2) check({tag, "_upd_early"}, int'(sel_upd), 0);
         if (e == D + 3) begin
            check({tag, "_upd_edge"}, int'(sel_upd), 1);
            check({tag, "_freq"}, int'(freq_sel), exp_f);
            check({tag, "_lp"}, int'(lp_sel), exp_l);
            check({tag, "_hp"}, int'(hp_sel), exp_h);
         end
         if (e == D + 4) check({tag, "_upd_late"}, int'(sel_upd), 0);
      end
      #1;
   endtask

   initial begin
      int su, se;
      n_tests = 0; n_fail = 0;
      upd_total = 0; err_total = 0; b2b_total = 0;
      prev_upd = 1'b0; prev_err = 1'b0;
      reset_n = 1'b0;
      btn_n   = 16'hFFFF;

      // Sequence after the latency test (freq=4, lp=0, hp=0), all D=4.
      add(16'h0004, 20, 2, 0, 0, 1, 0);
      add(16'h0000, 20, 2, 0, 0, 0, 0);
      add(16'h0200,  3, 2, 0, 0, 0, 0);
      add(16'h0000, 20, 2, 0, 0, 0, 0);
      add(16'h0200, 20, 2, 1, 0, 1, 0);
      add(16'h0000, 20, 2, 1, 0, 0, 0);
      add(16'h2008, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, 0, C_MP ? 1 : 0, 1);
      add(16'h0000, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, 0, 0, 0);
      add(16'h4000, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, 2, 1, 0);
      add(16'h4002, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, C_MP ? 0 : 2, C_MP ? 1 : 0, 1);
      add(16'h0002, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, C_MP ? 0 : 2, 0, 0);
      add(16'h0000, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, C_MP ? 0 : 2, 0, 0);
      add(16'h4000, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, 2, 1, 0);
      add(16'h0000, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, 2, 0, 0);
      add(16'h4000, 20, C_MP ? 5 : 2, C_MP ? 0 : 1, 2, 1, 0);
      add(16'h0001, 20, 0, C_MP ? 0 : 1, 2, 1, 0);
      add(16'h0080, 20, 7, C_MP ? 0 : 1, 2, 1, 0);
      add(16'h0100, 20, 7, 0, 2, 1, 0);
      add(16'h0800, 20, 7, 3, 2, 1, 0);
      add(16'h8000, 20, 7, 3, 3, 1, 0);
      add(16'h0000, 20, 7, 3, 3, 0, 0);

      // Reset state, both while held and after release.
      wait_cycles(3);
      check("rst_hold_freq", int'(freq_sel), 5);
      check("rst_hold_upd", int'(sel_upd), 0);
      reset_n = 1'b1;
      wait_cycles(5);
      @(negedge clk);
      check("rst_freq", int'(freq_sel), 5);
      check("rst_lp", int'(lp_sel), 0);
      check("rst_hp", int'(hp_sel), 0);
      check("rst_upd", int'(sel_upd), 0);
      check("rst_err", int'(multi_err), 0);
      after_edge();

      btn_n = ~16'h0010;
      latency_seq("lat", 4, 0, 0);
      btn_n = 16'hFFFF;
      wait_cycles(20);

      foreach (vecs[i]) begin
         su = upd_total;
         se = err_total;
         btn_n = ~vecs[i].mask;
         wait_cycles(vecs[i].cycles);
         check($sformatf("vec%0d_freq", i), int'(freq_sel), vecs[i].f);
         check($sformatf("vec%0d_lp", i), int'(lp_sel), vecs[i].l);
         check($sformatf("vec%0d_hp", i), int'(hp_sel), vecs[i].h);
         check($sformatf("vec%0d_upd", i), upd_total - su, vecs[i].upd);
         check($sformatf("vec%0d_err", i), err_total - se, vecs[i].err);
      end

      // Reset mid-debounce with bit 5 held, then the held button counts as a new press.
      su = upd_total;
      btn_n = ~16'h0020;
      wait_cycles(4);
      reset_n = 1'b0;
      #2;
      check("mid_rst_freq", int'(freq_sel), 5);
      check("mid_rst_lp", int'(lp_sel), 0);
      check("mid_rst_hp", int'(hp_sel), 0);
      check("mid_rst_no_upd", upd_total - su, 0);
      wait_cycles(2);
      reset_n = 1'b1;
      latency_seq("mid_rst", 5, 0, 0);
      btn_n = 16'hFFFF;
      wait_cycles(20);

      check("strobe_b2b", b2b_total, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
